// File: rtl/e203_exu_oitf_gen.sv
// Outstanding-instruction-track FIFO: one entry per long-pipe dispatch,
// in-order retire at long-pipe writeback, RAW/WAW hazard detection against
// every live entry, occupancy reporting and single-cycle flush.
module e203_exu_oitf_gen #(
  parameter int DEPTH   = 2,
  parameter int ITAG_W  = 1,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dis_ena,
  output logic               dis_ready,
  input  logic               dis_rdwen,
  input  logic [RFIDX_W-1:0] dis_rdidx,
  input  logic [PC_W-1:0]    dis_pc,
  output logic [ITAG_W-1:0]  dis_ptr,
  input  logic               ret_ena,
  output logic [ITAG_W-1:0]  ret_ptr,
  output logic               ret_rdwen,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic [PC_W-1:0]    ret_pc,
  input  logic               flush,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rs3en,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rs3idx,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprs3,
  output logic               oitfrd_match_disprd,
  output logic               oitf_empty,
  output logic               oitf_full,
  output logic [ITAG_W:0]    oitf_cnt
);

  // Per-entry state; payload (rdwen/rdidx/pc) is qualified by r_vld
  logic [DEPTH-1:0]              r_vld;
  logic [DEPTH-1:0]              r_rdwen;
  logic [DEPTH-1:0][RFIDX_W-1:0] r_rdidx;
  logic [DEPTH-1:0][PC_W-1:0]    r_pc;

  // Pointers carry the wrap flag in the MSB, so a plain +1 toggles it on wrap
  logic [ITAG_W:0] r_alc;
  logic [ITAG_W:0] r_ret;
  logic [ITAG_W:0] r_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_alc;
  logic              w_ret;
  logic [ITAG_W-1:0] w_alc_idx;
  logic [ITAG_W-1:0] w_ret_idx;
  logic [ITAG_W:0]   w_one;

  assign w_one     = {{ITAG_W{1'b0}}, 1'b1};
  assign w_alc_idx = r_alc[ITAG_W-1:0];
  assign w_ret_idx = r_ret[ITAG_W-1:0];
  assign w_empty   = (r_alc == r_ret);
  assign w_full    = (w_alc_idx == w_ret_idx) & (r_alc[ITAG_W] != r_ret[ITAG_W]);

  // Flush squashes both same-cycle allocation and retire
  assign w_alc = dis_ena & ~w_full & ~flush;
  assign w_ret = ret_ena & ~w_empty & ~flush;

  // Control state: valid bits, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_vld <= '0;
      r_alc <= '0;
      r_ret <= '0;
      r_cnt <= '0;
    end else begin
      // alc and ret can never target the same slot: equal indices mean empty or full
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alc && (w_alc_idx == ITAG_W'(i))) r_vld[i] <= 1'b1;
        if (w_ret && (w_ret_idx == ITAG_W'(i))) r_vld[i] <= 1'b0;
      end
      if (w_alc) r_alc <= r_alc + w_one;
      if (w_ret) r_ret <= r_ret + w_one;
      case ({w_alc, w_ret})
        2'b10:   r_cnt <= r_cnt + w_one;
        2'b01:   r_cnt <= r_cnt - w_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload capture on allocation; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_alc) begin
      r_rdwen[w_alc_idx] <= dis_rdwen;
      r_rdidx[w_alc_idx] <= dis_rdidx;
      r_pc[w_alc_idx]    <= dis_pc;
    end
  end

  assign dis_ready  = ~w_full;
  assign dis_ptr    = w_alc_idx;
  assign ret_ptr    = w_ret_idx;
  assign ret_rdwen  = ~w_empty & r_rdwen[w_ret_idx];
  assign ret_rdidx  = r_rdidx[w_ret_idx];
  assign ret_pc     = r_pc[w_ret_idx];
  assign oitf_empty = w_empty;
  assign oitf_full  = w_full;
  assign oitf_cnt   = r_cnt;

  // Per-entry hazard compare against the instruction currently in dispatch
  logic [DEPTH-1:0] w_hit_rs1, w_hit_rs2, w_hit_rs3, w_hit_rd;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic w_live;
    assign w_live       = r_vld[g] & r_rdwen[g];
    assign w_hit_rs1[g] = w_live & (r_rdidx[g] == disp_i_rs1idx);
    assign w_hit_rs2[g] = w_live & (r_rdidx[g] == disp_i_rs2idx);
    assign w_hit_rs3[g] = w_live & (r_rdidx[g] == disp_i_rs3idx);
    assign w_hit_rd[g]  = w_live & (r_rdidx[g] == disp_i_rdidx);
  end

  assign oitfrd_match_disprs1 = disp_i_rs1en & (|w_hit_rs1);
  assign oitfrd_match_disprs2 = disp_i_rs2en & (|w_hit_rs2);
  assign oitfrd_match_disprs3 = disp_i_rs3en & (|w_hit_rs3);
  assign oitfrd_match_disprd  = disp_i_rdwen & (|w_hit_rd);

endmodule
